avalon_port_arbiter: RTL

AVALON_PORT_ARBITER -- requirements
Module: avalon_port_arbiter

---
 rtl/avalon_port_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/avalon_port_arbiter.sv
// avalon_port_arbiter
// Arbitrates a read-only instruction port and a read/write data port onto a
// single Avalon-MM master. One transaction runs at a time through three states:
// IDLE (sample requests), BUS (drive the registered transfer until waitrequest
// drops) and DONE (one-cycle ack to the owner).
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   i_req, i_address                instruction request (always a 32-bit read)
//   i_ack, i_readdata               instruction completion pulse and last fetched word
//   d_req, d_write, d_address,      data request; d_write selects write (1) or read (0)
//   d_writedata, d_byteenable
//   d_ack, d_readdata               data completion pulse and last read word
//   address, read, write,           Avalon master outputs, registered, held for the
//   writedata, byteenable           whole BUS state
//   waitrequest, readdata           Avalon master inputs
//   busy                            high whenever the arbiter is not in IDLE
//
// Configuration:
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests go to the port that did
//                       not own the last completed transaction. Default (undefined)
//                       is fixed data-over-instruction priority.
module avalon_port_arbiter (
    input  logic        clk,
    input  logic        reset,
    // Instruction port
    input  logic        i_req,
    input  logic [31:0] i_address,
    output logic        i_ack,
    output logic [31:0] i_readdata,
    // Data port
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_address,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_ack,
    output logic [31:0] d_readdata,
    // Avalon master
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    // Status
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StBus,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;       // 1 = data port owns the transaction
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] i_readdata_q, i_readdata_d;
    logic [31:0] d_readdata_q, d_readdata_d;
    logic        grant_data;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_owner_q, last_owner_d; // 1 = data port completed last

    // On a tie, data wins only if instruction completed last.
    assign grant_data = d_req && !(i_req && last_owner_q);
`else
    assign grant_data = d_req;
`endif

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        i_readdata_d = i_readdata_q;
        d_readdata_d = d_readdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_owner_d = last_owner_q;
`endif

        case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    state_d = StBus;
                    owner_d = grant_data;
                    if (grant_data) begin
                        address_d    = d_address;
                        read_d       = !d_write;
                        write_d      = d_write;
                        writedata_d  = d_writedata;
                        byteenable_d = d_byteenable;
                    end else begin
                        address_d    = i_address;
                        read_d       = 1'b1;
                        write_d      = 1'b0;
                        writedata_d  = 32'h0;
                        byteenable_d = 4'hF;
                    end
                end
            end

            StBus: begin
                if (!waitrequest) begin
                    state_d = StDone;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (owner_q) begin
                        // A completed write must leave d_readdata untouched.
                        if (read_q) begin
                            d_readdata_d = readdata;
                        end
                    end else begin
                        i_readdata_d = readdata;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_owner_d = owner_q;
`endif
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            address_q    <= 32'h0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            writedata_q  <= 32'h0;
            byteenable_q <= 4'h0;
            i_readdata_q <= 32'h0;
            d_readdata_q <= 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            i_readdata_q <= i_readdata_d;
            d_readdata_q <= d_readdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign i_readdata = i_readdata_q;
    assign d_readdata = d_readdata_q;
    assign busy       = (state_q != StIdle);
    assign i_ack      = (state_q == StDone) && !owner_q;
    assign d_ack      = (state_q == StDone) && owner_q;

endmodule
